// File: rtl/dvs_ravens_pkg.sv
// Shared types for the DVS-to-RAVENS reader: event widths, reader FSM states,
// channel-tagged spike record and the wrap-safe timestamp comparison.
package dvs_ravens_pkg;

  localparam int EVENT_BITS        = 32;
  localparam int TIMESTAMP_US_BITS = 16;
  localparam int MAX_CH_BITS       = 4;

  typedef enum logic [1:0] {
    RDR_IDLE,
    RDR_REQ,
    RDR_RD_CTRL,
    RDR_RD
  } rdr_state_t;

  typedef struct packed {
    logic [MAX_CH_BITS-1:0] ch;
    logic [EVENT_BITS-1:0]  evt;
  } tagged_spike_t;

  localparam int SPIKE_BITS = $bits(tagged_spike_t);

  // Modular difference read as signed: valid while the true gap is under half the wrap period.
  function automatic logic ts_reached(input logic [TIMESTAMP_US_BITS-1:0] now,
                                      input logic [TIMESTAMP_US_BITS-1:0] ts);
    logic signed [TIMESTAMP_US_BITS-1:0] delta;
    delta = $signed(now - ts);
    return (delta >= 0);
  endfunction

endpackage

// File: rtl/dvs_spike_queue.sv
// Synchronous first-word-fall-through queue; head_o always shows the oldest entry.
module dvs_spike_queue #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_ok   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full queue is still accepted.
  assign wr_ok   = push_i && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dvs_multi_ch_ravens_reader.sv
// Round-robin reader of NUM_CH DVS event FIFOs feeding a channel-tagged spike
// queue, with optional timestamp-gated release towards the RAVENS transmitter.
module dvs_multi_ch_ravens_reader
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int TIMED_MODE = 1,
  parameter int GRANT_TO   = 15,
  localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0]              fifo_empty,
  input  logic [NUM_CH-1:0]              fifo_grant,
  input  logic [NUM_CH*EVENT_BITS-1:0]   fifo_event,
  input  logic [TIMESTAMP_US_BITS-1:0]   time_us,
  output logic [NUM_CH-1:0]              fifo_req,
  output logic [NUM_CH-1:0]              fifo_rd_en,
  output logic                           spike_valid,
  input  logic                           spike_ready,
  output logic [CH_BITS-1:0]             spike_ch,
  output logic [EVENT_BITS-1:0]          spike_event,
  output logic [15:0]                    drop_cnt
);

  localparam int TO_BITS  = (GRANT_TO > 1) ? $clog2(GRANT_TO + 1) : 1;
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_BITS-1:0] ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_BITS'(i) == ch) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rdr_state_t            state_q;
  logic [CH_BITS-1:0]    cur_ch_q;
  logic [CH_BITS-1:0]    rr_q;
  logic [CH_BITS-1:0]    rr_d;
  logic [TO_BITS-1:0]    to_q;
  logic [NUM_CH-1:0]     req_q;
  logic [NUM_CH-1:0]     rd_en_q;
  logic [15:0]           drop_q;

  logic [NUM_CH-1:0]     elig;
  logic [CH_BITS-1:0]    idx;
  logic [CH_BITS-1:0]    pick;
  logic                  pick_vld;
  logic [EVENT_BITS-1:0] cur_evt;

  logic                  push;
  tagged_spike_t         push_data;
  tagged_spike_t         head;
  logic                  q_empty;
  logic [CNT_BITS-1:0]   q_count;
  logic                  rel_ok;
  logic                  pop;

  assign elig = ch_en & ~fifo_empty;

  // First eligible channel at or after the round-robin pointer, wrapping.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_BITS'((int'(rr_q) + i) % NUM_CH);
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    cur_evt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_BITS'(i) == cur_ch_q) cur_evt = fifo_event[i*EVENT_BITS +: EVENT_BITS];
    end
  end

  assign rr_d = (cur_ch_q == CH_BITS'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RDR_IDLE;
      cur_ch_q <= '0;
      rr_q     <= '0;
      to_q     <= '0;
      req_q    <= '0;
      rd_en_q  <= '0;
      drop_q   <= '0;
    end else begin
      unique case (state_q)
        RDR_IDLE: begin
          // Admission at IDLE is what keeps the later push from overflowing the queue.
          if (pick_vld && (q_count <= CNT_BITS'(DEPTH - 1))) begin
            cur_ch_q <= pick;
            req_q    <= ch_onehot(pick);
            to_q     <= '0;
            state_q  <= RDR_REQ;
          end
        end
        RDR_REQ: begin
          if (|(fifo_grant & req_q)) begin
            rd_en_q <= req_q;
            state_q <= RDR_RD_CTRL;
          end else if (to_q == TO_BITS'(GRANT_TO - 1)) begin
            req_q   <= '0;
            drop_q  <= sat_inc16(drop_q);
            rr_q    <= rr_d;
            state_q <= RDR_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        RDR_RD_CTRL: begin
          rd_en_q <= '0;
          req_q   <= '0;
          state_q <= RDR_RD;
        end
        RDR_RD: begin
          rr_q    <= rr_d;
          state_q <= RDR_IDLE;
        end
        default: state_q <= RDR_IDLE;
      endcase
    end
  end

  // FIFO data arrives the cycle after rd_en, i.e. while in RD.
  always_comb begin
    push          = (state_q == RDR_RD);
    push_data.ch  = MAX_CH_BITS'(cur_ch_q);
    push_data.evt = cur_evt;
  end

  dvs_spike_queue #(
    .WIDTH (SPIKE_BITS),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign rel_ok      = (TIMED_MODE == 0) || ts_reached(time_us, head.evt[TIMESTAMP_US_BITS-1:0]);
  assign spike_valid = !q_empty && rel_ok;
  assign pop         = spike_valid && spike_ready;
  assign spike_ch    = q_empty ? '0 : head.ch[CH_BITS-1:0];
  assign spike_event = q_empty ? '0 : head.evt;

  assign fifo_req    = req_q;
  assign fifo_rd_en  = rd_en_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_dvs_multi_ch_ravens_reader.sv
// Directed bench for the multi-channel RAVENS reader: behavioural FIFO/grant
// model, bus-protocol monitors, table-driven vectors and corner-case sequences.
module tb_dvs_multi_ch_ravens_reader;
  import dvs_ravens_pkg::*;

  localparam int NCH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCH-1:0]         ch_en;
  logic [NCH-1:0]         fifo_empty;
  logic [NCH-1:0]         fifo_grant;
  logic [NCH*32-1:0]      fifo_event = '0;
  logic [15:0]            time_us;
  logic [NCH-1:0]         fifo_req;
  logic [NCH-1:0]         fifo_rd_en;
  logic                   spike_valid;
  logic                   spike_ready;
  logic [1:0]             spike_ch;
  logic [31:0]            spike_event;
  logic [15:0]            drop_cnt;

  always #5 clk = ~clk;

  dvs_multi_ch_ravens_reader #(
    .NUM_CH(NCH), .DEPTH(8), .TIMED_MODE(1), .GRANT_TO(15)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .fifo_empty(fifo_empty),
    .fifo_grant(fifo_grant), .fifo_event(fifo_event), .time_us(time_us),
    .fifo_req(fifo_req), .fifo_rd_en(fifo_rd_en), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_ch(spike_ch), .spike_event(spike_event),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [31:0] mk_evt(input int ch, input int seq, input logic [15:0] ts);
    return {4'hA, ch[3:0], seq[7:0], ts};
  endfunction

  function automatic int oh_index(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  // FIFO + grant model
  int             loaded[NCH]   = '{default: 0};
  int             consumed[NCH] = '{default: 0};
  logic [15:0]    evt_ts;
  logic [NCH-1:0] gnt_en;

  assign fifo_grant = fifo_req & gnt_en;

  always_comb begin
    for (int i = 0; i < NCH; i++) fifo_empty[i] = (loaded[i] == consumed[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (fifo_rd_en[i]) begin
        fifo_event[i*32 +: 32] <= mk_evt(i, consumed[i], evt_ts);
        consumed[i]            <= consumed[i] + 1;
      end
    end
  end

  // Monitors
  int             rd_log[$];
  logic [35:0]    acc_log[$];
  int             oh_viol   = 0;
  int             stab_viol = 0;
  logic           stab_en;
  logic [NCH-1:0] prev_rd   = '0;
  logic           pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [33:0]    pd = '0;

  always @(posedge clk) begin
    if (fifo_rd_en != '0) rd_log.push_back(oh_index(fifo_rd_en));
    if (($countones(fifo_rd_en) > 1) || ($countones(fifo_req) > 1) ||
        ((fifo_rd_en & ~fifo_req) != '0) || ((fifo_rd_en != '0) && (prev_rd != '0)))
      oh_viol <= oh_viol + 1;
    if (!rst && spike_valid && spike_ready) acc_log.push_back({2'b00, spike_ch, spike_event});
    if (stab_en && !prst && !rst && pv && !pr && !(spike_valid && ({spike_ch, spike_event} == pd)))
      stab_viol <= stab_viol + 1;
    prev_rd <= fifo_rd_en;
    pv      <= spike_valid;
    pr      <= spike_ready;
    pd      <= {spike_ch, spike_event};
    prst    <= rst;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rd_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, (rd_log.size() >= n), 1);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, (acc_log.size() >= n), 1);
  endtask

  typedef struct {
    logic [15:0] t;
    logic        exp_v;
  } tv_t;

  typedef struct {
    int ch;
    int rnd;
  } ord_t;

  tv_t  tv[10];
  ord_t ord[5];
  int   rd_base, acc_base, cnt, c1;
  int   cstart[NCH];
  logic all_done;

  initial begin
    tv[0] = '{16'hFFFE, 1'b0}; tv[1] = '{16'hFFFF, 1'b0}; tv[2] = '{16'h0000, 1'b0};
    tv[3] = '{16'h0001, 1'b0}; tv[4] = '{16'h0002, 1'b0}; tv[5] = '{16'h0004, 1'b0};
    tv[6] = '{16'h0005, 1'b1}; tv[7] = '{16'h0006, 1'b1}; tv[8] = '{16'h8004, 1'b1};
    tv[9] = '{16'h8005, 1'b0};
    ord[0] = '{0, 0}; ord[1] = '{1, 0}; ord[2] = '{2, 0}; ord[3] = '{3, 0}; ord[4] = '{0, 1};

    rst = 1'b1; ch_en = '0; gnt_en = '0; spike_ready = 1'b0; stab_en = 1'b1;
    time_us = 16'h0100; evt_ts = 16'h0010;
    repeat (3) @(negedge clk);
    chk("rst_req", fifo_req, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_ch", spike_ch, 0);
    chk("rst_event", spike_event, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    ch_en = 4'b1111; gnt_en = 4'b1111; spike_ready = 1'b1;
    @(negedge clk);

    // Single channel, minimum latency
    acc_base = acc_log.size();
    loaded[0] = 1;
    @(negedge clk);
    chk("t1_req", fifo_req, 4'b0001);
    chk("t1_rd_en_idle", fifo_rd_en, 0);
    @(negedge clk);
    chk("t1_rd_en", fifo_rd_en, 4'b0001);
    chk("t1_req_held", fifo_req, 4'b0001);
    @(negedge clk);
    chk("t1_rd_en_off", fifo_rd_en, 0);
    chk("t1_valid_early", spike_valid, 0);
    @(negedge clk);
    chk("t1_valid", spike_valid, 1);
    chk("t1_ch", spike_ch, 0);
    chk("t1_event", spike_event, mk_evt(0, 0, 16'h0010));
    @(negedge clk);
    chk("t1_popped", spike_valid, 0);
    chk("t1_accepted", acc_log.size() - acc_base, 1);

    // All channels busy, immediate grants
    do_reset();
    rd_base = rd_log.size(); acc_base = acc_log.size();
    for (int i = 0; i < NCH; i++) begin
      cstart[i] = consumed[i];
      loaded[i] = consumed[i] + 2;
    end
    wait_rd(rd_base + 5, 60, "t2_reads");
    wait_acc(acc_base + 5, 40, "t2_spikes");
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", rd_log[rd_base + k], ord[k].ch);
      chk("t2_spike", acc_log[acc_base + k],
          {2'b00, 2'(ord[k].ch), mk_evt(ord[k].ch, cstart[ord[k].ch] + ord[k].rnd, 16'h0010)});
    end
    repeat (20) @(negedge clk);

    // Grant timeout on ch2
    do_reset();
    gnt_en = 4'b1011;
    rd_base = rd_log.size();
    loaded[2] = consumed[2] + 1;
    cnt = 0;
    while (fifo_req != 4'b0100 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3_req_ch2", fifo_req, 4'b0100);
    loaded[3] = consumed[3] + 1;
    cnt = 0;
    while (fifo_req == 4'b0100 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("t3_req_cycles", cnt, 15);
    chk("t3_drop", drop_cnt, 1);
    @(negedge clk);
    chk("t3_req_ch3", fifo_req, 4'b1000);
    wait_rd(rd_base + 1, 20, "t3_read");
    chk("t3_served", rd_log[rd_base], 3);
    loaded[2] = consumed[2];
    repeat (10) @(negedge clk);
    chk("t3_drop_final", drop_cnt, 1);
    gnt_en = 4'b1111;

    // Back-pressure fills the queue
    do_reset();
    spike_ready = 1'b0;
    rd_base = rd_log.size();
    for (int i = 0; i < NCH; i++) begin
      cstart[i] = consumed[i];
      loaded[i] = consumed[i] + 10;
    end
    repeat (60) @(negedge clk);
    chk("t4_reads_full", rd_log.size() - rd_base, 8);
    chk("t4_no_req", fifo_req, 0);
    chk("t4_valid", spike_valid, 1);
    chk("t4_head", {spike_ch, spike_event}, {2'd0, mk_evt(0, cstart[0], 16'h0010)});
    acc_base = acc_log.size();
    spike_ready = 1'b1;
    wait_rd(rd_base + 9, 20, "t4_resume");
    chk("t4_first_acc", acc_log[acc_base], {2'b00, 2'd0, mk_evt(0, cstart[0], 16'h0010)});
    cnt = 0;
    all_done = 1'b0;
    while (!all_done && cnt < 400) begin
      @(negedge clk);
      cnt++;
      all_done = 1'b1;
      for (int i = 0; i < NCH; i++) if (loaded[i] != consumed[i]) all_done = 1'b0;
    end
    chk("t4_drained", all_done, 1);
    repeat (20) @(negedge clk);
    chk("t4_total_acc", acc_log.size() - acc_base, 40);

    // Reset during RD_CTRL
    do_reset();
    spike_ready = 1'b0;
    rd_base = rd_log.size();
    loaded[1] = consumed[1] + 3;
    wait_rd(rd_base + 2, 40, "t6_two_reads");
    cnt = 0;
    while (fifo_rd_en == '0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_in_rd_ctrl", fifo_rd_en, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_req", fifo_req, 0);
    chk("t6_rd_en", fifo_rd_en, 0);
    chk("t6_valid", spike_valid, 0);
    chk("t6_event", spike_event, 0);
    acc_base = acc_log.size();
    rst = 1'b0;
    spike_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_spike", acc_log.size() - acc_base, 0);
    chk("t6_consumed", consumed[1], loaded[1]);

    // Timed release across time_us wrap
    do_reset();
    spike_ready = 1'b0;
    stab_en = 1'b0;
    time_us = 16'hFFF0;
    evt_ts = 16'h0005;
    c1 = consumed[1];
    loaded[1] = consumed[1] + 1;
    repeat (8) @(negedge clk);
    chk("t5_held", spike_valid, 0);
    for (int k = 0; k < 10; k++) begin
      time_us = tv[k].t;
      #1;
      chk("t5_release", spike_valid, tv[k].exp_v);
      @(negedge clk);
    end
    time_us = 16'h0005;
    #1;
    chk("t5_valid", spike_valid, 1);
    chk("t5_ch", spike_ch, 1);
    chk("t5_event", spike_event, mk_evt(1, c1, 16'h0005));
    spike_ready = 1'b1;
    @(negedge clk);
    chk("t5_accepted", spike_valid, 0);
    stab_en = 1'b1;
    repeat (3) @(negedge clk);

    chk("onehot_bus", oh_viol, 0);
    chk("spike_stable", stab_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
